// File: rtl/bike_mode_sequencer.sv
// bike_mode_sequencer: OFF/ON/OFF/FLASH_k ring sequencer with one-hot mode select and speed-button routing.
// Define BIKE_IDLE_OFF_EN to compile in the idle auto-off counter; otherwise idle_off is tied to 0.
module bike_mode_sequencer #(
  parameter int NUM_FLASH = 2,
  parameter int RESET_INDEX = 0,
  parameter int IDLE_CYCLES = 1000,
  localparam int L = 2 * (NUM_FLASH + 1),
  localparam int IW = $clog2(L)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 next,
  input  logic                 prev,
  input  logic                 up_button,
  input  logic                 down_button,
  output logic [NUM_FLASH+1:0] state,
  output logic [IW-1:0]        mode_index,
  output logic [NUM_FLASH-1:0] shift_left,
  output logic [NUM_FLASH-1:0] shift_right,
  output logic                 idle_off
);
  if (NUM_FLASH < 1 || RESET_INDEX < 0 || RESET_INDEX >= L || IDLE_CYCLES < 2) begin : g_bad_params
    $error("bike_mode_sequencer: illegal parameter set");
  end
  // Even indices are OFF; odd index 2k+1 selects bit k+1 (ON is k=0).
  function automatic logic [NUM_FLASH+1:0] decode(input logic [IW-1:0] idx);
    return idx[0] ? {{(NUM_FLASH+1){1'b0}}, 1'b1} << ((idx >> 1) + 1'b1)
                  : {{(NUM_FLASH+1){1'b0}}, 1'b1};
  endfunction
  logic [IW-1:0] idx_inc, idx_dec, idx_nxt;
  logic          timeout;
  assign idx_inc = (mode_index == IW'(L - 1)) ? '0 : mode_index + 1'b1;
  assign idx_dec = (mode_index == '0) ? IW'(L - 1) : mode_index - 1'b1;
  // A timeout only fires in a cycle without activity, so it never competes with next/prev.
  assign idx_nxt = ((next && !prev) || timeout) ? idx_inc
                 : (prev && !next) ? idx_dec
                 : mode_index;
  // Index and its decoded one-hot are registered together so they never disagree.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_index <= IW'(RESET_INDEX);
      state      <= decode(IW'(RESET_INDEX));
    end else begin
      mode_index <= idx_nxt;
      state      <= decode(idx_nxt);
    end
  end
  // Buttons are masked while reset is low since the registered state may already select a flash.
  assign shift_left  = (reset && up_button && !down_button) ? state[NUM_FLASH+1:2] : '0;
  assign shift_right = (reset && down_button && !up_button) ? state[NUM_FLASH+1:2] : '0;
`ifdef BIKE_IDLE_OFF_EN
  localparam int CW = $clog2(IDLE_CYCLES);
  logic [CW-1:0] idle_cnt;
  logic          act;
  assign act     = next || prev || up_button || down_button;
  assign timeout = mode_index[0] && !act && (idle_cnt == CW'(IDLE_CYCLES - 1));
  // Counts idle cycles while lit; any activity, OFF, or the timeout itself restarts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_cnt <= '0;
      idle_off <= 1'b0;
    end else begin
      idle_cnt <= (!mode_index[0] || act || timeout) ? '0 : idle_cnt + 1'b1;
      idle_off <= timeout;
    end
  end
`else
  assign timeout  = 1'b0;
  assign idle_off = 1'b0;
`endif
endmodule

// File: tb/tb_bike_mode_sequencer.sv
// tb_bike_mode_sequencer: directed plus randomized checks against a ring-index reference model.
module tb_bike_mode_sequencer;
  localparam int NF = 2;
  localparam int L = 6;
  localparam int IDLE = 8;
  logic clk = 0, reset = 0, next = 0, prev = 0, up_button = 0, down_button = 0;
  logic [NF+1:0] state;
  logic [2:0] mode_index;
  logic [NF-1:0] shift_left, shift_right;
  logic idle_off;
  int passed = 0, total = 0;
  int m_idx = 0, m_cnt = 0;
  bit m_off = 0;
  always #5 clk = ~clk;
  bike_mode_sequencer #(.NUM_FLASH(NF), .RESET_INDEX(0), .IDLE_CYCLES(IDLE)) dut (
    .clk(clk), .reset(reset), .next(next), .prev(prev), .up_button(up_button),
    .down_button(down_button), .state(state), .mode_index(mode_index),
    .shift_left(shift_left), .shift_right(shift_right), .idle_off(idle_off)
  );
  function automatic logic [3:0] exp_state(input int i);
    return (i % 2 == 1) ? 4'(1 << ((i + 1) / 2)) : 4'b0001;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  task automatic check_outs();
    chk("mode_index", 32'(mode_index), 32'(m_idx));
    chk("state", 32'(state), 32'(exp_state(m_idx)));
    chk("idle_off", 32'(idle_off), 32'(m_off));
  endtask
  task automatic check_shift(input bit u, input bit d);
    logic [1:0] el, er;
    el = 2'b00;
    er = 2'b00;
    if (m_idx % 2 == 1 && m_idx > 1) begin
      if (u && !d) el = 2'(1 << ((m_idx - 1) / 2 - 1));
      if (d && !u) er = 2'(1 << ((m_idx - 1) / 2 - 1));
    end
    chk("shift_left", 32'(shift_left), 32'(el));
    chk("shift_right", 32'(shift_right), 32'(er));
  endtask
  task automatic cyc(input bit n, input bit p, input bit u, input bit d);
    bit act, to;
    next = n;
    prev = p;
    up_button = u;
    down_button = d;
    #1 check_shift(u, d);
    @(posedge clk);
    act = n | p | u | d;
    to = 0;
`ifdef BIKE_IDLE_OFF_EN
    to = (m_idx % 2 == 1) && !act && (m_cnt == IDLE - 1);
`endif
    m_cnt = (m_idx % 2 == 1 && !act && !to) ? m_cnt + 1 : 0;
    if ((n && !p) || to) m_idx = (m_idx + 1) % L;
    else if (p && !n) m_idx = (m_idx + L - 1) % L;
    m_off = to;
    #1 check_outs();
    @(negedge clk);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check_outs();
    up_button = 1;
    #1 chk("shift_in_reset", 32'({shift_left, shift_right}), 32'd0);
    up_button = 0;
    @(negedge clk);
    reset = 1;
    repeat (7) cyc(1, 0, 0, 0);
    chk("walk_end", 32'(mode_index), 32'd1);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk("prev_wrap", 32'(state), 32'b1000);
    cyc(1, 1, 0, 0);
    chk("conflict_hold", 32'(mode_index), 32'd5);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 1, 1);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 1);
`ifdef BIKE_IDLE_OFF_EN
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    repeat (8) cyc(0, 0, 0, 0);
    chk("idle_to_off", 32'({mode_index, idle_off}), 32'({3'd4, 1'b1}));
    cyc(0, 1, 0, 0);
    repeat (7) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 0);
    chk("idle_cancel", 32'(mode_index), 32'd3);
    repeat (8) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    repeat (6) cyc(0, 0, 0, 0);
`else
    repeat (4) cyc(1, 0, 0, 0);
`endif
    reset = 0;
    #1;
    chk("async_state", 32'(state), 32'b0001);
    chk("async_index", 32'(mode_index), 32'd0);
    m_idx = 0;
    m_cnt = 0;
    m_off = 0;
    @(negedge clk);
    reset = 1;
    repeat (10) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
`ifndef BIKE_IDLE_OFF_EN
    repeat (100) cyc(0, 0, 0, 0);
    chk("no_idle_off", 32'({mode_index, idle_off}), 32'({3'd1, 1'b0}));
`endif
    repeat (400) cyc($urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0,
                     $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
    next = 0;
    prev = 0;
    up_button = 0;
    down_button = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
